hci_core_r_credit_buffer: RTL

// - Sits between the source streamer's HCI-Core initiator port and the memory/interconnect target.
// - Memory r_valid cannot be stalled; the source drives r_ready from downstream stream.ready.
// - Block reserves one buffer slot per granted request (credit scheme) and stores responses in an in-order FIFO.
// - Result: no response is lost, and the source sees a clean valid/ready response channel.

---
 rtl/hci_core_r_credit_buffer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/hci_core_r_credit_buffer.sv
// rtl/hci_core_r_credit_buffer.sv - credit-reserved in-order response buffer for an HCI-Core initiator port (optional HCI_R_CREDIT_BUFFER_BYPASS_EN)
module hci_core_r_credit_buffer #(
    parameter int DW    = 64,
    parameter int AW    = 32,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              enable_i,
    // source-side request / response channel
    input  logic              tgt_req,
    output logic              tgt_gnt,
    input  logic [AW-1:0]     tgt_add,
    input  logic              tgt_wen,
    input  logic [DW/8-1:0]   tgt_be,
    input  logic [DW-1:0]     tgt_data,
    output logic [DW-1:0]     tgt_r_data,
    output logic              tgt_r_valid,
    input  logic              tgt_r_ready,
    // memory-side request / response channel
    output logic              ini_req,
    input  logic              ini_gnt,
    output logic [AW-1:0]     ini_add,
    output logic              ini_wen,
    output logic [DW/8-1:0]   ini_be,
    output logic [DW-1:0]     ini_data,
    input  logic [DW-1:0]     ini_r_data,
    input  logic              ini_r_valid,
    output logic              ini_r_ready,
    // status
    output logic [CNT_W-1:0]  credits_o,
    output logic              err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] reserved_q, reserved_d;
    logic [CNT_W-1:0] stored_q, stored_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic [DW-1:0]    mem_q [DEPTH];

    logic fifo_empty;
    logic has_credit;
    logic bypass;
    logic push;
    logic pop_fifo;
    logic resp_take;
    logic avail;
    logic issue;

    // Response path: credit check, optional zero-latency bypass, FIFO push/pop decode
    always_comb begin
        fifo_empty = (stored_q == '0);
        // a response is legitimate only if some reserved slot is still in flight
        has_credit = (reserved_q > stored_q);
`ifdef HCI_R_CREDIT_BUFFER_BYPASS_EN
        bypass      = fifo_empty & tgt_r_ready & ini_r_valid & has_credit;
        tgt_r_valid = !fifo_empty | bypass;
        tgt_r_data  = bypass ? ini_r_data : mem_q[rd_ptr_q];
`else
        bypass      = 1'b0;
        tgt_r_valid = !fifo_empty;
        tgt_r_data  = mem_q[rd_ptr_q];
`endif
        push      = ini_r_valid & has_credit & ~bypass;
        pop_fifo  = !fifo_empty & tgt_r_ready;
        resp_take = tgt_r_valid & tgt_r_ready;
    end

    // Request path: a slot being released this cycle may be re-granted immediately
    always_comb begin
        avail   = enable_i & ((reserved_q < DEPTH_C) | resp_take);
        ini_req = tgt_req & avail;
        tgt_gnt = ini_gnt & avail;
        issue   = ini_req & ini_gnt;
        ini_add     = tgt_add;
        ini_wen     = tgt_wen;
        ini_be      = tgt_be;
        ini_data    = tgt_data;
        ini_r_ready = 1'b1;
    end

    // Next-state for credits, occupancy, pointers and the sticky error
    always_comb begin
        reserved_d = reserved_q + CNT_W'(issue) - CNT_W'(resp_take);
        stored_d   = stored_q + CNT_W'(push) - CNT_W'(pop_fifo);
        wr_ptr_d   = push     ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
        err_d      = err_q | (ini_r_valid & ~has_credit);
        if (clear_i) begin
            reserved_d = '0;
            stored_d   = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            err_d      = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= '0;
            stored_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            stored_q   <= stored_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // Response storage; contents are qualified by stored_q so no reset is needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ini_r_data;
        end
    end

    assign credits_o = reserved_q;
    assign err_o     = err_q;

endmodule
